booth_dot_seq: RTL and testbench
================================

BOOTH_DOT_SEQ -- requirements
Module: booth_dot_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 11, the signed operand width fed to the shared Booth multiplier.
REQ-002 SHALL have parameter ACC_W, default 32, the signed accumulator width (ACC_W >= 2*WIDTH).
REQ-003 SHALL have parameter LEN_W, default 8, the width of the dot-product length field.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state on rising edge.
REQ-006 RST  input  1  asynchronous active-low reset.
REQ-007 start  input  1  job request; sampled only in IDLE.
REQ-008 len  input  LEN_W  number of operand pairs in job, sampled with start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 in_valid  input  1  operand pair valid.
REQ-011 in_ready  output  1  block can accept operand pair.
REQ-012 mx, my  input  WIDTH each  signed operands.
REQ-013 mul_mx, mul_my  output  WIDTH each  registered operands driven to the multiplier.
REQ-014 mul_sum, mul_carry  input  2*WIDTH each  redundant product returned combinationally by the multiplier.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 acc_out  output  ACC_W  signed dot-product result.
REQ-018 ovf  output  1  sticky signed overflow flag for the current job.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 latches len and clears acc, issue count, retire count, ovf and the stage-1 valid; next state RUN if len!=0, DONE if len==0.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in RUN with issue count < latched len; 0 in every other state.
REQ-023 Handshake (in_valid & in_ready) at an edge SHALL load mx/my into mul_mx/mul_my, set stage-1 valid v1, and increment issue count; without a handshake v1 SHALL clear and mul_mx/mul_my SHALL hold their values.
REQ-024 On an edge with v1=1: product = (mul_sum + mul_carry) modulo 2^(2*WIDTH), sign-extended to ACC_W; acc += product (ACC_W wrap); retire count increments.
REQ-025 ovf SHALL set when an accumulate adds two same-sign values and gives an opposite-sign result; it stays set until the next accepted start or reset.
REQ-026 RUN to DRAIN when issue count reaches len (on the edge of the last handshake).
REQ-027 DRAIN to DONE when retire count reaches len; result latency = 2 edges after the last handshake edge.
REQ-028 DONE: out_valid=1 and acc_out=acc, both held stable while out_ready=0; out_valid & out_ready returns the FSM to IDLE on that edge.
REQ-029 in_valid gaps (bubbles) in RUN SHALL not corrupt acc; v1=0 edges SHALL leave acc unchanged.
REQ-030 In IDLE, acc_out SHALL hold the last result.

Reset
REQ-031 RST=0 SHALL immediately force state IDLE and set busy, in_ready, out_valid, ovf, v1, mul_mx, mul_my, acc_out/acc, issue count and retire count to 0.
REQ-032 Reset asserted mid-job SHALL abandon the job; after release, no stale out_valid and no stale accumulate SHALL occur.

Verification
REQ-033 len=3, pairs (3,4),(-5,6),(1023,-1024), no bubbles -> out_valid 2 cycles after the 3rd handshake, acc_out=-1047570, ovf=0.
REQ-034 len=0 start -> DONE next edge, out_valid=1, acc_out=0, in_ready never asserted.
REQ-035 ACC_W=24, len=9, all pairs (-1024,-1024) -> ovf=1 after the 8th accumulate (sum 2^23); final acc_out = 9437184 mod 2^24 read as signed (-7340032).
REQ-036 len=4 with random in_valid bubbles and out_ready low for 5 cycles -> correct sum; acc_out/out_valid stable while stalled; start pulses during the job are ignored.
REQ-037 RST asserted in DRAIN -> all outputs 0 immediately; a new len=1 job with (2,-3) afterwards yields acc_out=-6.

Source files
------------

// File: rtl/booth_dot_seq.sv
// booth_dot_seq: sequential signed dot-product engine.
// One operand pair is handed to an external Booth multiplier per handshake.
// The multiplier returns the product in redundant sum/carry form one stage later.
// That product is resolved, sign-extended and folded into a wrapping accumulator.
// A sticky signed-overflow flag is kept for each job.
module booth_dot_seq #(
  parameter int WIDTH = 11,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  output logic [WIDTH-1:0]   mul_mx,
  output logic [WIDTH-1:0]   mul_my,
  input  logic [2*WIDTH-1:0] mul_sum,
  input  logic [2*WIDTH-1:0] mul_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issue_q, issue_d;
  logic [LEN_W-1:0]   retire_q, retire_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               v1_q, v1_d;
  logic [WIDTH-1:0]   mx_q, mx_d;
  logic [WIDTH-1:0]   my_q, my_d;

  logic [PW-1:0]      prod_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic               add_ovf_s;
  logic               in_ready_s;
  logic               hs_s;
  logic               issue_last_s;

  // Two's-complement overflow: both addends share a sign and the sum's sign differs.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    add_overflow = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Resolve the redundant product, sign-extend it and form the candidate accumulation.
  always_comb begin
    prod_s       = mul_sum + mul_carry;
    prod_ext_s   = ACC_W'($signed(prod_s));
    acc_sum_s    = acc_q + prod_ext_s;
    add_ovf_s    = add_overflow(acc_q[ACC_W-1], prod_ext_s[ACC_W-1], acc_sum_s[ACC_W-1]);
    in_ready_s   = (state_q == S_RUN) && (issue_q < len_q);
    hs_s         = in_valid && in_ready_s;
    issue_last_s = ((issue_q + LEN_W'(1)) == len_q);
  end

  // Next-state logic: operand issue, accumulate stage and job sequencing.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    mx_d     = mx_q;
    my_d     = my_q;
    v1_d     = hs_s;

    // Issue stage: capture operands on a handshake, otherwise hold them.
    if (hs_s) begin
      mx_d    = mx;
      my_d    = my;
      issue_d = issue_q + LEN_W'(1);
    end else begin
      mx_d    = mx_q;
      my_d    = my_q;
    end

    // Accumulate stage: only a valid stage-1 product touches the accumulator.
    if (v1_q) begin
      acc_d    = acc_sum_s;
      retire_d = retire_q + LEN_W'(1);
      if (add_ovf_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      acc_d    = acc_q;
      retire_d = retire_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len;
          acc_d    = {ACC_W{1'b0}};
          issue_d  = {LEN_W{1'b0}};
          retire_d = {LEN_W{1'b0}};
          ovf_d    = 1'b0;
          v1_d     = 1'b0;
          if (len == {LEN_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (hs_s && issue_last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The final product has retired once the count matches the job length.
        if (retire_q == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      len_q    <= {LEN_W{1'b0}};
      issue_q  <= {LEN_W{1'b0}};
      retire_q <= {LEN_W{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      ovf_q    <= 1'b0;
      v1_q     <= 1'b0;
      mx_q     <= {WIDTH{1'b0}};
      my_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      v1_q     <= v1_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    in_ready  = in_ready_s;
    out_valid = (state_q == S_DONE);
    acc_out   = acc_q;
    ovf       = ovf_q;
    mul_mx    = mx_q;
    mul_my    = my_q;
  end

endmodule

// File: tb/tb_booth_dot_seq.sv
// Bench for booth_dot_seq. The DUT runs with a narrow accumulator so overflow is reachable.
// The external multiplier is modelled with a product split into an arbitrary sum/carry pair.
module tb_booth_dot_seq;

  localparam int WIDTH = 11;
  localparam int ACC_W = 24;
  localparam int LEN_W = 8;
  localparam int PW    = 2 * WIDTH;

  logic             CLK;
  logic             RST;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mx, my;
  logic [WIDTH-1:0] mul_mx, mul_my;
  logic [PW-1:0]    mul_sum, mul_carry;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  booth_dot_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .mx(mx), .my(my),
    .mul_mx(mul_mx), .mul_my(mul_my), .mul_sum(mul_sum), .mul_carry(mul_carry),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Multiplier model: true product plus an operand-dependent offset, carry removes it.
  int            ma, mb;
  logic [PW-1:0] mp, mr;
  always_comb begin
    ma        = int'($signed(mul_mx));
    mb        = int'($signed(mul_my));
    mp        = PW'(ma * mb);
    mr        = PW'({mul_my, mul_mx} * 22'h2A5B3);
    mul_sum   = mp + mr;
    mul_carry = PW'(0) - mr;
  end

  typedef struct {
    longint acc;
    bit     ov;
    int     n;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     pmx[64];
  int     pmy[64];
  int     cyc = 0;
  int     last_hs = 0;
  int     stall_n = 0;
  bit     in_ep = 1'b0;
  longint held;
  longint last_acc;
  longint last_ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, wrapped to the accumulator range, overflow when out of range.
  function automatic void model(input int n, output longint acc, output bit ov);
    longint half, full, t;
    half = longint'(1) <<< (ACC_W - 1);
    full = half * 2;
    acc  = 0;
    ov   = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + longint'(pmx[i]) * longint'(pmy[i]);
      if (t >= half) begin
        ov = 1'b1;
        t  = t - full;
      end else if (t < -half) begin
        ov = 1'b1;
        t  = t + full;
      end
      acc = t;
    end
  endfunction

  // Edge counter and record of the last operand handshake.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST && in_valid && in_ready) last_hs <= cyc + 1;
  end

  // Consumer: random backpressure, with forced stalls on request.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (stall_n > 0) begin
        out_ready = 1'b0;
        stall_n   = stall_n - 1;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: pop expected result when a result appears, check it stays put while stalled.
  always @(negedge CLK) begin
    exp_t e;
    if (RST && out_valid) begin
      if (!in_ep) begin
        if (sb.size() == 0) begin
          chk("stale_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("acc_out", longint'($signed(acc_out)), e.acc);
          chk("ovf", longint'(ovf), longint'(e.ov));
          if (e.n != 0) chk("latency", longint'(cyc - last_hs), 2);
        end
        held     = longint'($signed(acc_out));
        last_acc = longint'($signed(acc_out));
        last_ovf = longint'(ovf);
        in_ep    = 1'b1;
      end else begin
        chk("stall_stable", longint'($signed(acc_out)), held);
      end
      if (out_ready) in_ep = 1'b0;
    end else begin
      in_ep = 1'b0;
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 500) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_job(input int n, input bit bubbles, input int stall, input bit abort);
    exp_t e;
    int   idx, guard;
    bit   hs;
    wait_idle();
    if (!abort) begin
      model(n, e.acc, e.ov);
      e.n = n;
      sb.push_back(e);
    end
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge CLK);
    #1;
    start = 1'b0;
    len   = LEN_W'($urandom);
    if (n == 0) begin
      chk("len0_in_ready", longint'(in_ready), 0);
      chk("len0_out_valid", longint'(out_valid), 1);
    end
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      mx       = WIDTH'(pmx[idx]);
      my       = WIDTH'(pmy[idx]);
      in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bubbles && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        len   = LEN_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      hs = in_valid && in_ready;
      @(posedge CLK);
      #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < n) chk("issue_timeout", idx, n);
    if (stall > 0) stall_n = stall + 3;
    if (abort) begin
      RST = 1'b0;
      #1;
      chk("rst_mid_job", longint'({busy, in_ready, out_valid, ovf, |acc_out, |mul_mx, |mul_my}), 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("post_rst_acc", longint'(acc_out), 0);
      chk("post_rst_busy", longint'(busy), 0);
    end else begin
      wait_idle();
    end
  endtask

  initial begin
    int n;
    RST      = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    mx       = '0;
    my       = '0;
    #1;
    chk("reset_outputs", longint'({busy, in_ready, out_valid, ovf, |acc_out, |mul_mx, |mul_my}), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // Three fixed pairs, no bubbles.
    pmx[0] = 3;    pmy[0] = 4;
    pmx[1] = -5;   pmy[1] = 6;
    pmx[2] = 1023; pmy[2] = -1024;
    run_job(3, 1'b0, 0, 1'b0);
    chk("fixed3_acc", last_acc, -1047570);
    chk("fixed3_ovf", last_ovf, 0);

    // Empty job.
    run_job(0, 1'b0, 0, 1'b0);
    chk("len0_acc", last_acc, 0);

    // Nine maximal positive products overflow the 24-bit accumulator.
    for (int i = 0; i < 9; i++) begin
      pmx[i] = -1024;
      pmy[i] = -1024;
    end
    run_job(9, 1'b0, 0, 1'b0);
    chk("ovf9_acc", last_acc, -7340032);
    chk("ovf9_flag", last_ovf, 1);

    // Four random pairs with bubbles, spurious starts and a five-cycle stall.
    for (int i = 0; i < 4; i++) begin
      pmx[i] = int'($urandom_range(0, 2047)) - 1024;
      pmy[i] = int'($urandom_range(0, 2047)) - 1024;
    end
    run_job(4, 1'b1, 5, 1'b0);

    // Reset while draining, then a short clean job.
    pmx[0] = 100; pmy[0] = 7;
    pmx[1] = -9;  pmy[1] = 11;
    run_job(2, 1'b0, 0, 1'b1);
    pmx[0] = 2;   pmy[0] = -3;
    run_job(1, 1'b0, 0, 1'b0);
    chk("after_rst_acc", last_acc, -6);

    // Random jobs.
    for (int j = 0; j < 12; j++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        pmx[i] = int'($urandom_range(0, 2047)) - 1024;
        pmy[i] = int'($urandom_range(0, 2047)) - 1024;
      end
      run_job(n, 1'b1, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
